bus_exec_reply: RTL and testbench
=================================

# bus_exec_reply

Executes register-bus transactions delivered by the host-packet decoder and streams a 5-byte reply packet back toward the FTDI transmit path. Each transaction is accepted once, issued on the internal register bus with wait-state and timeout handling, and answered with sync, address, data and checksum bytes. The block sits between the packet decoder and the host TX byte stream, closing the host→register→host loop.

## Interface
- TIMEOUT, 16: maximum `bus_stb` cycles before a transaction is aborted (range 1..255).
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- sink_stb  in  1  decoded transaction valid; held until acknowledged.
- sink_ack  out  1  single-cycle acceptance pulse.
- sink_wr  in  1  1 = write, 0 = read.
- sink_a  in  14  register address.
- sink_d  in  8  write data; ignored on reads.
- bus_stb  out  1  register-bus request.
- bus_ack  in  1  register-bus completion; sampled only while `bus_stb` = 1.
- bus_we  out  1  write enable.
- bus_a  out  14  address.
- bus_dout  out  8  write data.
- bus_din  in  8  read data; valid in the `bus_ack` cycle.
- source_stb  out  1  reply byte valid.
- source_ack  in  1  reply byte taken.
- source_d  out  8  reply byte.

## Operation
- Reset values (`rst_n` low at a `clk` edge):
  - state IDLE.
  - `sink_ack`, `bus_stb`, `bus_we`, `source_stb` = 0.
  - `bus_a` = 0, `bus_dout` = 0, `source_d` = 0.
  - Internal latches, timeout counter and checksum = 0.
  - A reset mid-transaction abandons it silently; no partial reply resumes.
- All outputs are registered.
- FSM states: IDLE → BUS → SYNC → ADRH → ADRL → DATA → CKSUM → IDLE.
- IDLE:
  - On `sink_stb` = 1, latch `sink_wr`, `sink_a` and `sink_d`; assert `sink_ack` for exactly one cycle; go to BUS.
  - `sink_stb` is ignored in every other state.
- BUS:
  - Hold `bus_stb` = 1 with `bus_we`, `bus_a` and `bus_dout` stable from the latched values.
  - Count cycles with `bus_stb` = 1.
  - If `bus_ack` = 1: capture read data (`bus_din` on reads, latched write data on writes), clear the error flag, drop `bus_stb`, go to SYNC.
  - If `bus_ack` = 0 on cycle TIMEOUT: set the error flag, data = 0xFF, drop `bus_stb`, go to SYNC.
  - If `bus_ack` arrives on cycle TIMEOUT, the ack wins and no error is flagged.
- Reply states:
  - Each reply state presents one byte with `source_stb` = 1.
  - The byte transfers in a cycle with `source_stb` & `source_ack`; the FSM then advances.
  - `source_d` is held while `source_stb` = 1 and `source_ack` = 0.
- Reply bytes:
  - SYNC = 0x55.
  - ADRH = {wr, err, a[13:8]}.
  - ADRL = a[7:0].
  - DATA = data.
  - CKSUM = (0x55 + ADRH + ADRL + DATA) mod 256, accumulated in 8 bits with wrap.
- After the CKSUM transfer: drop `source_stb`, return to IDLE. The next transaction can be accepted one cycle later.

## Timing
- Acceptance: `sink_stb` sampled high in IDLE at edge N gives `sink_ack` = 1 during cycle N+1 and `bus_stb` = 1 from N+1.
- `sink_ack` is 0 again from N+2.
- Zero-wait bus (`bus_ack` high in the first `bus_stb` cycle): `source_stb` rises with SYNC in the cycle after the ack.
- Reply throughput: one byte per cycle when `source_ack` is held high. Minimum transaction-to-end-of-reply is 7 cycles after acceptance.
- `bus_stb` is never asserted for more than TIMEOUT consecutive cycles.
- `bus_stb` and `source_stb` are never high in the same cycle.

## Structure
- Shared package holds:
  - FSM state encoding (3 bits).
  - SYNC_BYTE = 8'h55.
  - TIMEOUT_DATA = 8'hFF.
  - ADRH bit positions: WR = 7, ERR = 6.
  - Address width of 14.
- The decoder uses the same sync and bit constants.
- Single flat module; no sub-module is warranted. The checksum is an 8-bit accumulator cleared in IDLE.

## Test plan
- Write, wr=1, a=0x0123, d=0xA5, bus_ack on the first cycle:
  - bus sees we=1, a=0x0123, dout=0xA5.
  - Reply is 0x55, 0x81, 0x23, 0xA5, 0x9E.
- Read, a=0x0010, bus_ack after 3 wait cycles with bus_din=0x3C:
  - Reply is 0x55, 0x00, 0x10, 0x3C, 0xA1.
- Read, a=0x0005, bus_ack never asserted:
  - bus_stb is high for exactly 16 cycles.
  - Reply is 0x55, 0x40, 0x05, 0xFF, 0x99.
- Backpressure: source_ack toggles 0/1 each cycle during the reply.
  - Bytes are unchanged and not duplicated.
  - source_d is stable while stalled.
  - sink_stb held high during the reply yields no second sink_ack until IDLE.
- Reset low during the ADRL byte, then release:
  - All outputs are 0 on the next cycle.
  - The next accepted transaction produces a complete, correct 5-byte reply.
- Boundary: bus_ack arrives on the 16th bus_stb cycle for a read of 0x3FFF with din=0x00.
  - No error flag.
  - Reply is 0x55, 0x3F, 0xFF, 0x00, 0x93.

Source files
------------

// File: rtl/bus_exec_reply_pkg.sv
// Shared constants and FSM encoding for the register-bus executor and the host packet decoder.
package bus_exec_reply_pkg;

  localparam int unsigned ADDR_W       = 14;
  localparam logic [7:0]  SYNC_BYTE    = 8'h55;
  localparam logic [7:0]  TIMEOUT_DATA = 8'hFF;
  localparam int unsigned ADRH_WR_BIT  = 7;
  localparam int unsigned ADRH_ERR_BIT = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BUS   = 3'd1,
    ST_SYNC  = 3'd2,
    ST_ADRH  = 3'd3,
    ST_ADRL  = 3'd4,
    ST_DATA  = 3'd5,
    ST_CKSUM = 3'd6
  } state_e;

  function automatic logic [7:0] adrh_byte(input logic wr, input logic err,
                                           input logic [ADDR_W-1:0] a);
    logic [7:0] b;
    b               = {2'b00, a[ADDR_W-1:8]};
    b[ADRH_WR_BIT]  = wr;
    b[ADRH_ERR_BIT] = err;
    return b;
  endfunction

endpackage

// File: rtl/bus_exec_reply_if.sv
// Decoder sink, register bus and reply byte stream seen by bus_exec_reply.
interface bus_exec_reply_if;
  import bus_exec_reply_pkg::*;

  logic              sink_stb;
  logic              sink_ack;
  logic              sink_wr;
  logic [ADDR_W-1:0] sink_a;
  logic [7:0]        sink_d;

  logic              bus_stb;
  logic              bus_ack;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_a;
  logic [7:0]        bus_dout;
  logic [7:0]        bus_din;

  logic              source_stb;
  logic              source_ack;
  logic [7:0]        source_d;

  modport slave (
    input  sink_stb, sink_wr, sink_a, sink_d, bus_ack, bus_din, source_ack,
    output sink_ack, bus_stb, bus_we, bus_a, bus_dout, source_stb, source_d
  );

  modport master (
    output sink_stb, sink_wr, sink_a, sink_d, bus_ack, bus_din, source_ack,
    input  sink_ack, bus_stb, bus_we, bus_a, bus_dout, source_stb, source_d
  );

endinterface

// File: rtl/bus_exec_reply.sv
// Accepts one decoded transaction, runs it on the register bus with a timeout,
// then streams the 5-byte reply (sync, adrh, adrl, data, checksum).
module bus_exec_reply
  import bus_exec_reply_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst_n,
  bus_exec_reply_if.slave  io
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_e            state_q;
  logic              wr_q;
  logic              err_q;
  logic [ADDR_W-1:0] a_q;
  logic [7:0]        d_q;
  logic [7:0]        data_q;
  logic [7:0]        cnt_q;
  logic [7:0]        cksum_q;

  logic              sink_ack_q;
  logic              bus_stb_q;
  logic              bus_we_q;
  logic [ADDR_W-1:0] bus_a_q;
  logic [7:0]        bus_dout_q;
  logic              source_stb_q;
  logic [7:0]        source_d_q;

  logic [7:0]        adrh_d;
  logic              xfer;

  assign adrh_d = adrh_byte(wr_q, err_q, a_q);
  assign xfer   = source_stb_q & io.source_ack;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_q         <= 1'b0;
      err_q        <= 1'b0;
      a_q          <= '0;
      d_q          <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
      cksum_q      <= '0;
      sink_ack_q   <= 1'b0;
      bus_stb_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_a_q      <= '0;
      bus_dout_q   <= '0;
      source_stb_q <= 1'b0;
      source_d_q   <= '0;
    end else begin
      sink_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cksum_q <= '0;
          if (io.sink_stb) begin
            wr_q       <= io.sink_wr;
            a_q        <= io.sink_a;
            d_q        <= io.sink_d;
            sink_ack_q <= 1'b1;
            bus_stb_q  <= 1'b1;
            bus_we_q   <= io.sink_wr;
            bus_a_q    <= io.sink_a;
            bus_dout_q <= io.sink_d;
            cnt_q      <= 8'd1;
            state_q    <= ST_BUS;
          end
        end
        ST_BUS: begin
          // cnt_q is the 1-based index of the current bus_stb cycle; ack beats timeout
          if (io.bus_ack || cnt_q == TMO) begin
            err_q        <= ~io.bus_ack;
            data_q       <= io.bus_ack ? (wr_q ? d_q : io.bus_din) : TIMEOUT_DATA;
            bus_stb_q    <= 1'b0;
            source_stb_q <= 1'b1;
            source_d_q   <= SYNC_BYTE;
            cksum_q      <= SYNC_BYTE;
            state_q      <= ST_SYNC;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_SYNC: if (xfer) begin
          source_d_q <= adrh_d;
          cksum_q    <= cksum_q + adrh_d;
          state_q    <= ST_ADRH;
        end
        ST_ADRH: if (xfer) begin
          source_d_q <= a_q[7:0];
          cksum_q    <= cksum_q + a_q[7:0];
          state_q    <= ST_ADRL;
        end
        ST_ADRL: if (xfer) begin
          source_d_q <= data_q;
          cksum_q    <= cksum_q + data_q;
          state_q    <= ST_DATA;
        end
        ST_DATA: if (xfer) begin
          source_d_q <= cksum_q;
          state_q    <= ST_CKSUM;
        end
        ST_CKSUM: if (xfer) begin
          source_stb_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign io.sink_ack   = sink_ack_q;
  assign io.bus_stb    = bus_stb_q;
  assign io.bus_we     = bus_we_q;
  assign io.bus_a      = bus_a_q;
  assign io.bus_dout   = bus_dout_q;
  assign io.source_stb = source_stb_q;
  assign io.source_d   = source_d_q;

endmodule

// File: tb/tb_bus_exec_reply.sv
// Bench for bus_exec_reply: directed and random transactions against a reply-packet reference model.
module tb_bus_exec_reply;

  localparam int TIMEOUT = 16;

  logic clk;
  logic rst_n;
  int   nchk;
  int   npass;

  bus_exec_reply_if io();

  bus_exec_reply #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sink_ack"},   io.sink_ack,   0);
    chk({tag, "_bus_stb"},    io.bus_stb,    0);
    chk({tag, "_bus_we"},     io.bus_we,     0);
    chk({tag, "_bus_a"},      io.bus_a,      0);
    chk({tag, "_bus_dout"},   io.bus_dout,   0);
    chk({tag, "_source_stb"}, io.source_stb, 0);
    chk({tag, "_source_d"},   io.source_d,   0);
  endtask

  // ack_at: 1-based bus_stb cycle carrying bus_ack, 0 = never.
  // bp: 0 = source_ack always high, 1 = toggling, 2 = random.
  task automatic run_txn(input logic wr, input logic [13:0] a, input logic [7:0] d,
                         input int ack_at, input logic [7:0] din, input int bp,
                         input logic hold_sink);
    logic [7:0] exp_b [5];
    logic [7:0] got   [5];
    logic       err;
    logic [7:0] data;
    int         sum;
    int         stb_cycles;
    int         nb;
    int         guard;
    logic       prev_stall;
    logic [7:0] prev_d;
    logic       sa;

    err  = (ack_at == 0);
    data = err ? 8'hFF : (wr ? d : din);
    exp_b[0] = 8'h55;
    exp_b[1] = 8'((wr ? 128 : 0) + (err ? 64 : 0) + (int'(a) / 256));
    exp_b[2] = 8'(int'(a) % 256);
    exp_b[3] = data;
    sum = 0;
    for (int i = 0; i < 4; i++) sum += int'(exp_b[i]);
    exp_b[4] = 8'(sum % 256);

    io.sink_stb = 1'b1;
    io.sink_wr  = wr;
    io.sink_a   = a;
    io.sink_d   = d;
    step();
    chk("accept_sink_ack", io.sink_ack, 1);
    chk("accept_bus_stb",  io.bus_stb,  1);
    if (!hold_sink) begin
      io.sink_stb = 1'b0;
      io.sink_a   = 14'($urandom);
    end

    stb_cycles = 0;
    while (io.bus_stb && stb_cycles < TIMEOUT + 4) begin
      stb_cycles++;
      chk("bus_we",   io.bus_we,   wr);
      chk("bus_a",    io.bus_a,    a);
      if (wr) chk("bus_dout", io.bus_dout, d);
      if (stb_cycles > 1) chk("sink_ack_pulse", io.sink_ack, 0);
      io.bus_ack = (stb_cycles == ack_at);
      io.bus_din = io.bus_ack ? din : 8'($urandom);
      step();
    end
    io.bus_ack = 1'b0;
    chk("bus_stb_cycles", stb_cycles, err ? TIMEOUT : ack_at);
    chk("reply_start", io.source_stb, 1);

    nb = 0;
    guard = 0;
    prev_stall = 1'b0;
    prev_d = '0;
    while (nb < 5 && guard < 200) begin
      guard++;
      if (prev_stall) chk("stall_hold", io.source_d, prev_d);
      chk("stb_exclusive", io.bus_stb & io.source_stb, 0);
      chk("no_sink_ack_in_reply", io.sink_ack, 0);
      case (bp)
        0:       sa = 1'b1;
        1:       sa = guard[0];
        default: sa = 1'($urandom);
      endcase
      io.source_ack = sa;
      if (io.source_stb && sa) begin
        got[nb] = io.source_d;
        nb++;
      end
      prev_stall = io.source_stb & ~sa;
      prev_d     = io.source_d;
      step();
    end
    io.source_ack = 1'b0;
    io.sink_stb   = 1'b0;
    chk("reply_count", nb, 5);
    for (int i = 0; i < 5; i++)
      if (i < nb) chk($sformatf("reply_byte%0d", i), got[i], exp_b[i]);
    chk("idle_source_stb", io.source_stb, 0);
    chk("idle_sink_ack",   io.sink_ack,   0);
  endtask

  initial begin
    nchk  = 0;
    npass = 0;
    rst_n = 1'b0;
    io.sink_stb   = 1'b0;
    io.sink_wr    = 1'b0;
    io.sink_a     = '0;
    io.sink_d     = '0;
    io.bus_ack    = 1'b0;
    io.bus_din    = '0;
    io.source_ack = 1'b0;
    step();
    step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Directed cases
    run_txn(1'b1, 14'h0123, 8'hA5, 1,       8'h00, 0, 1'b0);
    run_txn(1'b0, 14'h0010, 8'h00, 4,       8'h3C, 0, 1'b0);
    run_txn(1'b0, 14'h0005, 8'h00, 0,       8'h00, 0, 1'b0);
    run_txn(1'b0, 14'h2A6B, 8'h11, 2,       8'hC7, 1, 1'b1);
    run_txn(1'b0, 14'h3FFF, 8'h00, TIMEOUT, 8'h00, 0, 1'b0);

    // Reset while the ADRL byte is being presented
    io.sink_stb = 1'b1;
    io.sink_wr  = 1'b0;
    io.sink_a   = 14'h1234;
    step();
    io.sink_stb = 1'b0;
    io.bus_ack  = 1'b1;
    io.bus_din  = 8'h77;
    step();
    io.bus_ack    = 1'b0;
    io.source_ack = 1'b1;
    step();
    step();
    io.source_ack = 1'b0;
    chk("pre_reset_adrl", io.source_d, 8'h34);
    rst_n = 1'b0;
    step();
    chk_all_zero("midreset");
    rst_n = 1'b1;
    step();
    chk("no_resume", io.source_stb, 0);
    run_txn(1'b1, 14'h0ABC, 8'h5A, 3, 8'h00, 2, 1'b0);

    // Random transactions
    for (int n = 0; n < 24; n++) begin
      int ack;
      ack = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
      run_txn(1'($urandom), 14'($urandom), 8'($urandom), ack, 8'($urandom),
              int'($urandom_range(0, 2)), 1'($urandom));
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
